// File: rtl/bridge_mailbox_pkg.sv
// Shared types for the bridge mailbox endpoint.
// Register map enum and the sticky/status flag bundle.
package bridge_mailbox_pkg;

  typedef enum logic [1:0] {
    MBOX_DATA   = 2'd0,
    MBOX_STATUS = 2'd1,
    MBOX_FLAGS  = 2'd2,
    MBOX_STATS  = 2'd3
  } bridge_mailbox_reg_e;

  typedef struct packed {
    logic tx_full;
    logic rx_empty;
    logic underflow;
    logic overflow;
  } mbox_flags_t;

  localparam int unsigned MBOX_WINDOW_BITS = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bridge_if.sv
// Host bridge leaf bus: one-cycle wr/rd strobes,
// registered read data returned by the endpoint.
interface bridge_if #(
  parameter int data_width = 32
);
  logic [31:0]           addr;
  logic [data_width-1:0] wr_data;
  logic                  wr;
  logic                  rd;
  logic [data_width-1:0] rd_data;

  modport leaf (
    input  addr,
    input  wr_data,
    input  wr,
    input  rd,
    output rd_data
  );

  modport host (
    output addr,
    output wr_data,
    output wr,
    output rd,
    input  rd_data
  );
endinterface

// File: rtl/bridge_mailbox_fifo.sv
// Synchronous FIFO with flush; flush wins over push/pop.
// A push into a full FIFO is taken only alongside a pop.
module bridge_mailbox_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bridge_mailbox.sv
// Bridge leaf mailbox: host->core RX FIFO, core->host TX FIFO.
// Define BRIDGE_MAILBOX_STATS_EN for drop/underflow counters at reg 3.
module bridge_mailbox
  import bridge_mailbox_pkg::*;
#(
  parameter int          data_width = 32,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bridge_if.leaf                bridge,
  output logic [data_width-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [data_width-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  typedef logic [data_width-1:0] word_t;

  if (data_width != bridge.data_width) begin : g_bad_width
    $error("bridge_mailbox: data_width differs from bridge");
  end
  if (ADDR_BASE[3:0] != 4'h0) begin : g_bad_base
    $error("bridge_mailbox: ADDR_BASE not 16-byte aligned");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bridge_mailbox: DEPTH must be a power of 2 in 2..256");
  end

  logic                hit;
  logic                wr_hit;
  logic                rd_hit;
  bridge_mailbox_reg_e sel;
  logic                is_data;
  logic                is_status;
  logic                is_flags;
  logic                is_stats;
  logic                unused_addr;

  assign hit    = bridge.addr[31:MBOX_WINDOW_BITS]
               == ADDR_BASE[31:MBOX_WINDOW_BITS];
  assign sel    = bridge_mailbox_reg_e'(bridge.addr[3:2]);
  assign wr_hit = hit && bridge.wr;
  assign rd_hit = hit && bridge.rd;

  assign is_data   = sel == MBOX_DATA;
  assign is_status = sel == MBOX_STATUS;
  assign is_flags  = sel == MBOX_FLAGS;
  assign is_stats  = sel == MBOX_STATS;
  assign unused_addr = ^bridge.addr[1:0];

  logic          rx_flush;
  logic          rx_push;
  logic          rx_pop;
  logic [CW-1:0] rx_count;
  logic          rx_full;
  logic          rx_empty;

  logic          tx_flush;
  logic          tx_push;
  logic          tx_pop;
  word_t         tx_head;
  logic [CW-1:0] tx_count;
  logic          tx_full;
  logic          tx_empty;

  logic flags_wr;
  logic clr_ovf;
  logic clr_unf;
  logic ovf_event;
  logic unf_event;

  assign flags_wr = wr_hit && is_flags;
  assign rx_flush = flags_wr && bridge.wr_data[0];
  assign tx_flush = flags_wr && bridge.wr_data[1];
  assign clr_ovf  = flags_wr && bridge.wr_data[2];
  assign clr_unf  = flags_wr && bridge.wr_data[3];

  assign rx_push   = wr_hit && is_data;
  assign rx_pop    = rx_valid && rx_ready;
  assign ovf_event = rx_push && rx_full && !rx_pop;

  assign tx_ready  = !tx_full;
  assign tx_push   = tx_valid && tx_ready;
  assign tx_pop    = rd_hit && is_data && !tx_empty;
  assign unf_event = rd_hit && is_data && tx_empty;

  assign rx_valid = !rx_empty;

  bridge_mailbox_fifo #(
    .WIDTH (data_width),
    .DEPTH (DEPTH)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .flush     (rx_flush),
    .push      (rx_push),
    .push_data (bridge.wr_data),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  bridge_mailbox_fifo #(
    .WIDTH (data_width),
    .DEPTH (DEPTH)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .flush     (tx_flush),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  logic        overflow;
  logic        underflow;
  mbox_flags_t flags;

  assign flags = {tx_full, rx_empty, underflow, overflow};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_ovf)        overflow  <= 1'b0;
      else if (ovf_event) overflow  <= 1'b1;
      if (clr_unf)        underflow <= 1'b0;
      else if (unf_event) underflow <= 1'b1;
    end
  end

  word_t stats_word;

`ifdef BRIDGE_MAILBOX_STATS_EN
  logic        stats_wr;
  logic [15:0] ovf_drops;
  logic [15:0] unf_reads;

  assign stats_wr   = wr_hit && is_stats;
  assign stats_word = word_t'({ovf_drops, unf_reads});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_drops <= '0;
      unf_reads <= '0;
    end else if (stats_wr) begin
      ovf_drops <= '0;
      unf_reads <= '0;
    end else begin
      if (ovf_event) ovf_drops <= sat_inc16(ovf_drops);
      if (unf_event) unf_reads <= sat_inc16(unf_reads);
    end
  end
`else
  assign stats_word = '0;
`endif

  word_t rd_word;
  word_t rd_q;

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      is_data:   rd_word = tx_empty ? '0 : tx_head;
      is_status: rd_word = word_t'({16'(tx_count), 16'(rx_count)});
      is_flags:  rd_word = word_t'(flags);
      is_stats:  rd_word = stats_word;
      default:   rd_word = '0;
    endcase
  end

  // read data holds until the next hit read; misses leave it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      irq  <= 1'b0;
    end else begin
      if (rd_hit) rd_q <= rd_word;
      irq <= tx_count != '0;
    end
  end

  assign bridge.rd_data = rd_q;

endmodule
